gcd_lcm: RTL and testbench



---
 rtl/gcd_lcm_if.sv | 26 ++
 rtl/gcd_lcm.sv | 92 +++++++++
 tb/tb_gcd_lcm.sv | 114 +++++++++++
 3 files changed

// File: rtl/gcd_lcm_if.sv
// gcd_lcm_if: operand/result bus between a controller and gcd_lcm.
// The o_busy signal exists only when GCD_LCM_BUSY_EN is defined.
interface gcd_lcm_if #(parameter int SIZE = 8);
   logic                i_start;
   logic [SIZE-1:0]     i_data_in;
   logic                o_done;
   logic [SIZE-1:0]     o_gcd;
   logic [2*SIZE:0]     o_lcm;
`ifdef GCD_LCM_BUSY_EN
   logic                o_busy;
`endif
   modport master (
      output i_start, i_data_in,
      input  o_done, o_gcd, o_lcm
`ifdef GCD_LCM_BUSY_EN
      , input o_busy
`endif
   );
   modport slave (
      input  i_start, i_data_in,
      output o_done, o_gcd, o_lcm
`ifdef GCD_LCM_BUSY_EN
      , output o_busy
`endif
   );
endinterface

// File: rtl/gcd_lcm.sv
// gcd_lcm: serial-load GCD (subtractive Euclid) and LCM = (A/GCD)*B calculator.
// Define GCD_LCM_BUSY_EN to add the o_busy status output.
module gcd_lcm #(
   parameter int SIZE = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   gcd_lcm_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LOAD_B, GCD, DIV, MUL, DONE} state_t;
   state_t              r_state;
   logic [SIZE-1:0]     r_a, r_b, r_x, r_y, r_g, r_r, r_q, r_gcd;
   logic [2*SIZE:0]     r_lcm;
   logic                r_done;
   logic [2*SIZE-1:0]   w_prod;
   logic                w_zero;
   // quotient A/GCD is at most A, so SIZE bits suffice and the product never overflows 2*SIZE
   assign w_prod = {{SIZE{1'b0}}, r_q} * {{SIZE{1'b0}}, r_b};
   assign w_zero = (r_a == '0) || (bus.i_data_in == '0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_g     <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_gcd   <= '0;
         r_lcm   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  r_a     <= bus.i_data_in;
                  r_state <= LOAD_B;
               end else r_state <= IDLE;
            end
            LOAD_B: begin
               r_b <= bus.i_data_in;
               r_x <= r_a;
               r_y <= bus.i_data_in;
               if (w_zero) begin
                  r_gcd   <= r_a | bus.i_data_in;
                  r_lcm   <= '0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else r_state <= GCD;
            end
            GCD: begin
               if (r_x > r_y) r_x <= r_x - r_y;
               else if (r_y > r_x) r_y <= r_y - r_x;
               else begin
                  r_g     <= r_x;
                  r_r     <= r_a;
                  r_q     <= '0;
                  r_state <= DIV;
               end
            end
            DIV: begin
               if (r_r >= r_g) begin
                  r_r <= r_r - r_g;
                  r_q <= r_q + SIZE'(1);
               end else r_state <= MUL;
            end
            MUL: begin
               r_lcm   <= {1'b0, w_prod};
               r_gcd   <= r_g;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.o_done = r_done;
   assign bus.o_gcd  = r_gcd;
   assign bus.o_lcm  = r_lcm;
`ifdef GCD_LCM_BUSY_EN
   logic r_busy;
   // tracks the state being entered, so busy lines up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= 1'b0;
      else if (r_state == IDLE || r_state == DONE) r_busy <= bus.i_start;
      else r_busy <= !(r_state == MUL || (r_state == LOAD_B && w_zero));
   end
   assign bus.o_busy = r_busy;
`endif
endmodule

// File: tb/tb_gcd_lcm.sv
// tb_gcd_lcm: table-driven and randomized self-checking bench for gcd_lcm.
module tb_gcd_lcm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gcd_lcm_if #(.SIZE(8)) bus();
   gcd_lcm #(.SIZE(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {int a; int b; int g; int l; bit noisy;} vec_t;
   vec_t tv[7];
   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: modular Euclid; subtractive step count is the sum of quotients minus one.
   function automatic void model(input int a, input int b, output int g, output int l, output int lat);
      int x, y, t, s;
      if (a == 0 || b == 0) begin
         g = a | b; l = 0; lat = 1;
      end else begin
         x = a; y = b; s = 0;
         while (y != 0) begin
            s += x / y; t = x % y; x = y; y = t;
         end
         g = x; l = (a / g) * b; lat = (s - 1) + a / g + 4;
      end
   endfunction

   task automatic op(input int a, input int b, input int eg, input int el, input bit noisy, input string tag);
      int g, l, lat, n;
      model(a, b, g, l, lat);
      @(negedge clk); bus.i_start = 1'b1; bus.i_data_in = 8'(a);
      @(negedge clk); bus.i_start = 1'b0; bus.i_data_in = 8'(b);
      n = 0;
      do begin
         @(negedge clk); n++;
         if (!bus.o_done) begin
            bus.i_start = noisy ? 1'($urandom) : 1'b0;
            bus.i_data_in = 8'($urandom);
         end
      end while (!bus.o_done && n < 700);
      bus.i_start = 1'b0;
      chk({tag, " done_seen"}, 32'(bus.o_done), 1);
      chk({tag, " latency"}, n, lat);
      chk({tag, " gcd"}, 32'(bus.o_gcd), eg);
      chk({tag, " lcm"}, 32'(bus.o_lcm), el);
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(bus.o_done), 0);
      repeat (3) @(negedge clk);
      chk({tag, " gcd_hold"}, 32'(bus.o_gcd), eg);
      chk({tag, " lcm_hold"}, 32'(bus.o_lcm), el);
   endtask

   initial begin
      int g, l, lat, a, b, dn;
      tv[0] = '{100, 20, 20, 100, 1'b0};
      tv[1] = '{12, 18, 6, 36, 1'b0};
      tv[2] = '{0, 45, 45, 0, 1'b0};
      tv[3] = '{0, 0, 0, 0, 1'b0};
      tv[4] = '{255, 254, 1, 64770, 1'b1};
      tv[5] = '{1, 255, 1, 255, 1'b1};
      tv[6] = '{45, 0, 45, 0, 1'b0};
      bus.i_start = 1'b0;
      bus.i_data_in = '0;
      repeat (3) @(negedge clk);
      chk("reset done", 32'(bus.o_done), 0);
      chk("reset gcd", 32'(bus.o_gcd), 0);
      chk("reset lcm", 32'(bus.o_lcm), 0);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 6; i++) begin
         bus.i_data_in = 8'($urandom);
         @(negedge clk);
         dn += int'(bus.o_done);
      end
      chk("idle no done", dn, 0);
      for (int i = 0; i < 7; i++)
         op(tv[i].a, tv[i].b, tv[i].g, tv[i].l, tv[i].noisy, $sformatf("vec%0d", i));
      // reset in the middle of a long GCD phase
      @(negedge clk); bus.i_start = 1'b1; bus.i_data_in = 8'd200;
      @(negedge clk); bus.i_start = 1'b0; bus.i_data_in = 8'd3;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst gcd", 32'(bus.o_gcd), 0);
      chk("midrst lcm", 32'(bus.o_lcm), 0);
      chk("midrst done", 32'(bus.o_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (300) begin
         @(negedge clk);
         dn += int'(bus.o_done);
      end
      chk("midrst lost op", dn, 0);
      op(7, 21, 7, 21, 1'b0, "post_rst");
      for (int i = 0; i < 40; i++) begin
         a = (i % 10 == 3) ? 0 : int'($urandom_range(1, 255));
         b = (i % 10 == 7) ? 0 : int'($urandom_range(1, 255));
         model(a, b, g, l, lat);
         op(a, b, g, l, 1'b1, $sformatf("rnd%0d(%0d,%0d)", i, a, b));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
